// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
//   Shared definitions for the 8-bit CPU control path: opcode encoding,
//   control-word bit positions and masks, the opcode-independent fetch words
//   and the sequencer run/halt state.
package cpu_ctrl_pkg;

   typedef logic [15:0] ctrl_word_t;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0,
      OP_LDA = 4'h1,
      OP_ADD = 4'h2,
      OP_SUB = 4'h3,
      OP_STA = 4'h4,
      OP_LDI = 4'h5,
      OP_JMP = 4'h6,
      OP_JC  = 4'h7,
      OP_JZ  = 4'h8,
      OP_OUT = 4'hE,
      OP_HLT = 4'hF
   } opcode_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } seq_state_e;

   // Control-word bit positions.
   localparam int CTRL_HLT = 15;
   localparam int CTRL_MI  = 14;
   localparam int CTRL_RI  = 13;
   localparam int CTRL_RO  = 12;
   localparam int CTRL_IO  = 11;
   localparam int CTRL_II  = 10;
   localparam int CTRL_AI  = 9;
   localparam int CTRL_AO  = 8;
   localparam int CTRL_EO  = 7;
   localparam int CTRL_SU  = 6;
   localparam int CTRL_BI  = 5;
   localparam int CTRL_OI  = 4;
   localparam int CTRL_CE  = 3;
   localparam int CTRL_CO  = 2;
   localparam int CTRL_J   = 1;
   localparam int CTRL_FI  = 0;

   // Single-bit masks built from the indices above.
   localparam ctrl_word_t C_HLT = ctrl_word_t'(16'h0001) << CTRL_HLT;
   localparam ctrl_word_t C_MI  = ctrl_word_t'(16'h0001) << CTRL_MI;
   localparam ctrl_word_t C_RI  = ctrl_word_t'(16'h0001) << CTRL_RI;
   localparam ctrl_word_t C_RO  = ctrl_word_t'(16'h0001) << CTRL_RO;
   localparam ctrl_word_t C_IO  = ctrl_word_t'(16'h0001) << CTRL_IO;
   localparam ctrl_word_t C_II  = ctrl_word_t'(16'h0001) << CTRL_II;
   localparam ctrl_word_t C_AI  = ctrl_word_t'(16'h0001) << CTRL_AI;
   localparam ctrl_word_t C_AO  = ctrl_word_t'(16'h0001) << CTRL_AO;
   localparam ctrl_word_t C_EO  = ctrl_word_t'(16'h0001) << CTRL_EO;
   localparam ctrl_word_t C_SU  = ctrl_word_t'(16'h0001) << CTRL_SU;
   localparam ctrl_word_t C_BI  = ctrl_word_t'(16'h0001) << CTRL_BI;
   localparam ctrl_word_t C_OI  = ctrl_word_t'(16'h0001) << CTRL_OI;
   localparam ctrl_word_t C_CE  = ctrl_word_t'(16'h0001) << CTRL_CE;
   localparam ctrl_word_t C_CO  = ctrl_word_t'(16'h0001) << CTRL_CO;
   localparam ctrl_word_t C_J   = ctrl_word_t'(16'h0001) << CTRL_J;
   localparam ctrl_word_t C_FI  = ctrl_word_t'(16'h0001) << CTRL_FI;

   // Strobes that drive the shared bus; at most one may be active per word.
   localparam ctrl_word_t BUS_DRIVERS = C_CO | C_RO | C_IO | C_AO | C_EO;

   // Opcode-independent fetch words.
   localparam ctrl_word_t FETCH_T0 = C_CO | C_MI;
   localparam ctrl_word_t FETCH_T1 = C_RO | C_II | C_CE;

endpackage

// File: rtl/control_sequencer_chk.sv
// control_sequencer_chk
//   Simulation-only checker: no control word may enable more than one bus driver.
//   Ports:
//     clk, rst     sampling clock and asynchronous active-high reset
//     ctrl_i [15:0] control word under observation
module control_sequencer_chk
   import cpu_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  ctrl_word_t  ctrl_i
);

   a_one_bus_driver: assert property (@(posedge clk) disable iff (rst)
                                      $onehot0(ctrl_i & BUS_DRIVERS));

endmodule

// File: rtl/microcode_rom.sv
// microcode_rom
//   Purely combinational microcode table.
//   Ports:
//     opcode_i   [3:0] instruction register upper nibble
//     step_i     [2:0] current T-state
//     flag_c_i         carry flag (only consulted by JC at T2)
//     flag_z_i         zero flag  (only consulted by JZ at T2)
//     word_o     [15:0] control word for (opcode, step, flags)
//     is_last_o        every word after step_i up to NUM_STEPS-1 is zero
module microcode_rom
   import cpu_ctrl_pkg::*;
#(
   parameter int NUM_STEPS = 5
) (
   input  logic [3:0]  opcode_i,
   input  logic [2:0]  step_i,
   input  logic        flag_c_i,
   input  logic        flag_z_i,
   output ctrl_word_t  word_o,
   output logic        is_last_o
);

   // Microcode lookup; T-states at or beyond NUM_STEPS never emit strobes.
   function automatic ctrl_word_t ucode(input logic [3:0] op, input logic [2:0] t,
                                        input logic fc, input logic fz);
      ctrl_word_t w;
      w = 16'h0000;
      case (t)
         3'd0: w = FETCH_T0;
         3'd1: w = FETCH_T1;
         3'd2: begin
            case (opcode_e'(op))
               OP_LDA, OP_ADD, OP_SUB, OP_STA: w = C_IO | C_MI;
               OP_LDI: w = C_IO | C_AI;
               OP_JMP: w = C_IO | C_J;
               OP_JC:  w = fc ? (C_IO | C_J) : 16'h0000;
               OP_JZ:  w = fz ? (C_IO | C_J) : 16'h0000;
               OP_OUT: w = C_AO | C_OI;
               OP_HLT: w = C_HLT;
               default: w = 16'h0000;
            endcase
         end
         3'd3: begin
            case (opcode_e'(op))
               OP_LDA: w = C_RO | C_AI;
               OP_ADD, OP_SUB: w = C_RO | C_BI;
               OP_STA: w = C_AO | C_RI;
               default: w = 16'h0000;
            endcase
         end
         3'd4: begin
            case (opcode_e'(op))
               OP_ADD: w = C_EO | C_AI | C_FI;
               OP_SUB: w = C_EO | C_AI | C_SU | C_FI;
               default: w = 16'h0000;
            endcase
         end
         default: w = 16'h0000;
      endcase
      if (int'(t) >= NUM_STEPS) begin
         w = 16'h0000;
      end
      return w;
   endfunction

   ctrl_word_t tail_s;

   // Current word plus OR of all later words, which decides early termination.
   always_comb begin
      word_o = ucode(opcode_i, step_i, flag_c_i, flag_z_i);
      tail_s = 16'h0000;
      for (int s = 1; s < 8; s++) begin
         tail_s = tail_s | ((s > int'(step_i)) ?
                            ucode(opcode_i, 3'(s), flag_c_i, flag_z_i) : 16'h0000);
      end
      is_last_o = (tail_s == 16'h0000);
   end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer
//   Microcode sequencer for the 8-bit CPU: steps the T-state counter through
//   fetch and execute, decodes the control word and owns the halt state.
//   Ports:
//     clk          system clock
//     rst          asynchronous active-high reset
//     opcode_i [3:0] instruction register upper nibble
//     flag_c_i     registered carry flag
//     flag_z_i     registered zero flag
//     ctrl_o  [15:0] control word (combinational from step/halt/opcode/flags)
//     step_o  [2:0]  current T-state
//     halted_o     CPU stopped
module control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int NUM_STEPS = 5,
   parameter bit EARLY_END = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  opcode_i,
   input  logic        flag_c_i,
   input  logic        flag_z_i,
   output ctrl_word_t  ctrl_o,
   output logic [2:0]  step_o,
   output logic        halted_o
);

   localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

   seq_state_e  state_q, state_d;
   logic [2:0]  step_q, step_d;
   ctrl_word_t  rom_word_s;
   logic        is_last_s;
   logic        end_now_s;

   microcode_rom #(.NUM_STEPS(NUM_STEPS)) u_rom (
      .opcode_i  (opcode_i),
      .step_i    (step_q),
      .flag_c_i  (flag_c_i),
      .flag_z_i  (flag_z_i),
      .word_o    (rom_word_s),
      .is_last_o (is_last_s)
   );

   // State and T-state registers; reset lands directly on the T0 fetch word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
         step_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
      end
   end

   // Next-state: halt freezes the step; otherwise wrap at the last step or
   // as soon as the rest of the execute phase would be idle.
   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      end_now_s = 1'b0;
      case (state_q)
         ST_RUN: begin
            end_now_s = EARLY_END && (step_q >= 3'd2) && is_last_s;
            if (rom_word_s[CTRL_HLT]) begin
               state_d = ST_HALT;
               step_d  = step_q;
            end else if ((step_q == LAST_STEP) || end_now_s) begin
               state_d = ST_RUN;
               step_d  = 3'd0;
            end else begin
               state_d = ST_RUN;
               step_d  = step_q + 3'd1;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
            step_d  = step_q;
         end
         default: begin
            state_d = ST_RUN;
            step_d  = 3'd0;
         end
      endcase
   end

   // While halted every strobe is suppressed.
   assign ctrl_o   = (state_q == ST_RUN) ? rom_word_s : 16'h0000;
   assign step_o   = step_q;
   assign halted_o = (state_q == ST_HALT);

   control_sequencer_chk u_chk (
      .clk    (clk),
      .rst    (rst),
      .ctrl_i (ctrl_o)
   );

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//   Two sequencer instances (EARLY_END=1 as index 0, EARLY_END=0 as index 1)
//   are driven cycle by cycle and compared against a table-driven model of
//   instruction words and instruction lengths.
module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  op_w     [2];
   logic        fc_w     [2];
   logic        fz_w     [2];
   logic [15:0] ctrl_w   [2];
   logic [2:0]  step_w   [2];
   logic        halted_w [2];

   int n_vec = 0;
   int n_bad = 0;

   // Model state per instance.
   logic [3:0]  m_op [2];
   bit          m_fc [2];
   bit          m_fz [2];
   int          m_t  [2];
   int          m_ln [2];
   bit          m_h  [2];

   localparam logic [15:0] BUS_MASK = 16'h1984; // CO|RO|IO|AO|EO

   always #5 clk = ~clk;

   control_sequencer #(.NUM_STEPS(5), .EARLY_END(1'b1)) dut_e (
      .clk(clk), .rst(rst), .opcode_i(op_w[0]), .flag_c_i(fc_w[0]), .flag_z_i(fz_w[0]),
      .ctrl_o(ctrl_w[0]), .step_o(step_w[0]), .halted_o(halted_w[0]));

   control_sequencer #(.NUM_STEPS(5), .EARLY_END(1'b0)) dut_n (
      .clk(clk), .rst(rst), .opcode_i(op_w[1]), .flag_c_i(fc_w[1]), .flag_z_i(fz_w[1]),
      .ctrl_o(ctrl_w[1]), .step_o(step_w[1]), .halted_o(halted_w[1]));

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Word emitted at T-state t, straight from the instruction table.
   function automatic logic [15:0] model_word(input logic [3:0] op, input bit fc,
                                              input bit fz, input int t);
      logic [15:0] ex [3];
      ex[0] = 16'h0000; ex[1] = 16'h0000; ex[2] = 16'h0000;
      case (op)
         4'h1: begin ex[0] = 16'h4800; ex[1] = 16'h1200; end
         4'h2: begin ex[0] = 16'h4800; ex[1] = 16'h1020; ex[2] = 16'h0281; end
         4'h3: begin ex[0] = 16'h4800; ex[1] = 16'h1020; ex[2] = 16'h02C1; end
         4'h4: begin ex[0] = 16'h4800; ex[1] = 16'h2100; end
         4'h5: ex[0] = 16'h0A00;
         4'h6: ex[0] = 16'h0802;
         4'h7: ex[0] = fc ? 16'h0802 : 16'h0000;
         4'h8: ex[0] = fz ? 16'h0802 : 16'h0000;
         4'hE: ex[0] = 16'h0110;
         4'hF: ex[0] = 16'h8000;
         default: ex[0] = 16'h0000;
      endcase
      if (t == 0) return 16'h4004;
      if (t == 1) return 16'h1408;
      if (t >= 2 && t <= 4) return ex[t-2];
      return 16'h0000;
   endfunction

   // Instruction length in cycles: full 5, or trimmed after the last non-zero word.
   function automatic int model_len(input logic [3:0] op, input bit fc, input bit fz,
                                    input bit early);
      int last;
      if (!early) return 5;
      last = 1;
      for (int t = 2; t <= 4; t++) begin
         if (model_word(op, fc, fz, t) != 16'h0000) last = t;
      end
      return (last < 2) ? 3 : last + 1;
   endfunction

   // Assert rst (async), check the immediate reset view, release after a posedge.
   task automatic apply_reset();
      rst = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         check_eq($sformatf("rst_ctrl%0d", d), 32'(ctrl_w[d]), 32'h4004);
         check_eq($sformatf("rst_step%0d", d), 32'(step_w[d]), 32'd0);
         check_eq($sformatf("rst_halt%0d", d), 32'(halted_w[d]), 32'd0);
         m_t[d] = 0; m_ln[d] = 0; m_h[d] = 1'b0;
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // One clock cycle: drive inputs at negedge, compare shortly after.
   task automatic tick(input bit pick_random);
      logic [15:0] exp;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         if (!m_h[d] && m_t[d] == m_ln[d]) begin
            m_t[d] = 0;
            if (pick_random) begin
               m_op[d] = 4'($urandom_range(0, 14));
               m_fc[d] = 1'($urandom_range(0, 1));
               m_fz[d] = 1'($urandom_range(0, 1));
            end
            m_ln[d] = model_len(m_op[d], m_fc[d], m_fz[d], d == 0);
         end
         op_w[d] = m_op[d];
         // Flags only matter up to T2; afterwards they wander freely.
         fc_w[d] = (m_t[d] <= 2) ? m_fc[d] : 1'($urandom_range(0, 1));
         fz_w[d] = (m_t[d] <= 2) ? m_fz[d] : 1'($urandom_range(0, 1));
      end
      #1;
      for (int d = 0; d < 2; d++) begin
         exp = m_h[d] ? 16'h0000 : model_word(m_op[d], m_fc[d], m_fz[d], m_t[d]);
         check_eq($sformatf("ctrl%0d_op%0h_t%0d", d, m_op[d], m_t[d]), 32'(ctrl_w[d]), 32'(exp));
         check_eq($sformatf("step%0d_op%0h", d, m_op[d]), 32'(step_w[d]), 32'(m_t[d]));
         check_eq($sformatf("halt%0d_op%0h", d, m_op[d]), 32'(halted_w[d]), 32'(m_h[d]));
         check_eq($sformatf("bus%0d", d), 32'($countones(ctrl_w[d] & BUS_MASK) <= 1), 32'd1);
         if (!m_h[d]) begin
            if (exp[15]) m_h[d] = 1'b1;
            else m_t[d] = m_t[d] + 1;
         end
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         op_w[d] = 4'h0; fc_w[d] = 1'b0; fz_w[d] = 1'b0;
         m_op[d] = 4'h0; m_fc[d] = 1'b0; m_fz[d] = 1'b0;
         m_t[d] = 0; m_ln[d] = 0; m_h[d] = 1'b0;
      end
      #2;
      apply_reset();

      // LDA directed: 4004,1408,4800,1200 then back to T0 on the early-end instance.
      for (int d = 0; d < 2; d++) begin m_op[d] = 4'h1; m_fc[d] = 1'b0; m_fz[d] = 1'b0; end
      for (int i = 0; i < 6; i++) tick(1'b0);

      // Randomized instruction stream (no HLT).
      apply_reset();
      for (int i = 0; i < 400; i++) tick(1'b1);

      // Reset in the middle of ADD T3.
      apply_reset();
      for (int d = 0; d < 2; d++) begin m_op[d] = 4'h2; m_fc[d] = 1'b0; m_fz[d] = 1'b0; end
      for (int i = 0; i < 4; i++) tick(1'b0);
      apply_reset();

      // HLT: halts at T2 and stays frozen until reset.
      for (int d = 0; d < 2; d++) begin m_op[d] = 4'hF; m_fc[d] = 1'b0; m_fz[d] = 1'b0; end
      for (int i = 0; i < 23; i++) tick(1'b0);
      apply_reset();

      // Sweep every opcode and flag combination through one instruction.
      for (int op = 0; op < 16; op++) begin
         for (int f = 0; f < 4; f++) begin
            apply_reset();
            for (int d = 0; d < 2; d++) begin
               m_op[d] = 4'(op); m_fc[d] = f[0]; m_fz[d] = f[1];
            end
            for (int i = 0; i < 5; i++) tick(1'b0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
